// File: rtl/pipe_regfiles.sv
// Architectural register state: 32x32 GPR file with registered write-first reads,
// plus the control-register file (mode, exception capture, interrupt status).
module pipe_regfiles (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we1,
    input  logic        we2,
    input  logic [4:0]  wa1,
    input  logic [4:0]  wa2,
    input  logic [31:0] wd1,
    input  logic [31:0] wd2,
    output logic [31:0] ret_val,
    input  logic [4:0]  cr_raddr,
    output logic [31:0] cr_rdata,
    input  logic        cr_we,
    input  logic        exc_in_wb,
    input  logic        tlb_exc_in_wb,
    input  logic        interrupt_in_wb,
    input  logic        rfe_in_wb,
    input  logic        rfi_in_wb,
    input  logic [31:0] epc,
    input  logic [31:0] efg,
    input  logic [31:0] tlb_addr,
    input  logic [15:0] interrupts,
    output logic        kmode,
    output logic [31:0] cdv,
    output logic [31:0] interrupt_state
);

    typedef enum logic [4:0] {
        CR_PSR = 5'd0, CR_PID = 5'd1, CR_ISR = 5'd2, CR_IMR = 5'd3, CR_EPC = 5'd4,
        CR_EFG = 5'd5, CR_TLB = 5'd6, CR_KSP = 5'd7, CR_CDV = 5'd8
    } cr_idx_e;

    logic [31:0] r_gpr [32];
    logic [31:0] r_rs1_data, r_rs2_data, r_cr_rdata;
    logic [2:0]  r_psr;
    logic [15:0] r_isr, r_imr;
    logic [31:0] r_pid, r_epc, r_efg, r_tlb, r_ksp, r_cdv;

    logic [2:0]  w_psr_n;
    logic [15:0] w_isr_n, w_imr_n;
    logic [31:0] w_pid_n, w_epc_n, w_efg_n, w_tlb_n, w_ksp_n, w_cdv_n;
    logic [31:0] w_rs1_n, w_rs2_n, w_cr_rd_n;
    logic [15:0] w_istate;
    logic        w_irq_any;
    logic [3:0]  w_irq_idx;
    logic        w_exc_any;

    // Write-first read: port 1 forwarding is checked first so it wins on a shared address.
    function automatic logic [31:0] gpr_fwd(input logic [4:0] a);
        if (a == 5'd0)                return '0;
        else if (we1 && (wa1 == a))   return wd1;
        else if (we2 && (wa2 == a))   return wd2;
        else                          return r_gpr[a];
    endfunction

    always_comb begin
        w_rs1_n = gpr_fwd(rs1_addr);
        w_rs2_n = gpr_fwd(rs2_addr);
    end

    assign w_istate = r_psr[2] ? (r_isr & r_imr) : '0;

    always_comb begin
        w_irq_any = 1'b0;
        w_irq_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (w_istate[i]) begin
                w_irq_any = 1'b1;
                w_irq_idx = 4'(i);
            end
        end
    end

    assign w_exc_any = exc_in_wb || tlb_exc_in_wb || interrupt_in_wb;

    // Events are applied in priority order on the running next-state values.
    always_comb begin
        w_psr_n = r_psr;
        w_isr_n = r_isr;
        w_imr_n = r_imr;
        w_pid_n = r_pid;
        w_epc_n = r_epc;
        w_efg_n = r_efg;
        w_tlb_n = r_tlb;
        w_ksp_n = r_ksp;
        w_cdv_n = r_cdv;
        if (cr_we) begin
            case (wa1)
                CR_PSR:  w_psr_n = wd1[2:0];
                CR_PID:  w_pid_n = wd1;
                CR_ISR:  w_isr_n = wd1[15:0];
                CR_IMR:  w_imr_n = wd1[15:0];
                CR_EPC:  w_epc_n = wd1;
                CR_EFG:  w_efg_n = wd1;
                CR_TLB:  w_tlb_n = wd1;
                CR_KSP:  w_ksp_n = wd1;
                CR_CDV:  w_cdv_n = wd1;
                default: ;
            endcase
        end
        w_isr_n = w_isr_n | interrupts;
        if (rfe_in_wb) w_psr_n[0] = w_psr_n[1];
        if (rfi_in_wb) begin
            w_psr_n[0] = w_psr_n[1];
            w_psr_n[2] = 1'b1;
        end
        if (w_exc_any) begin
            w_epc_n    = epc;
            w_efg_n    = efg;
            w_psr_n[1] = w_psr_n[0];
            w_psr_n[0] = 1'b1;
        end
        if (tlb_exc_in_wb) w_tlb_n = tlb_addr;
        if (interrupt_in_wb) begin
            w_psr_n[2] = 1'b0;
            if (w_irq_any) w_isr_n[w_irq_idx] = 1'b0;
        end
    end

    always_comb begin
        case (cr_raddr)
            CR_PSR:  w_cr_rd_n = {29'd0, w_psr_n};
            CR_PID:  w_cr_rd_n = w_pid_n;
            CR_ISR:  w_cr_rd_n = {16'd0, w_isr_n};
            CR_IMR:  w_cr_rd_n = {16'd0, w_imr_n};
            CR_EPC:  w_cr_rd_n = w_epc_n;
            CR_EFG:  w_cr_rd_n = w_efg_n;
            CR_TLB:  w_cr_rd_n = w_tlb_n;
            CR_KSP:  w_cr_rd_n = w_ksp_n;
            CR_CDV:  w_cr_rd_n = w_cdv_n;
            default: w_cr_rd_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) r_gpr[i] <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_cr_rdata <= '0;
            r_psr      <= 3'b001;
            r_isr      <= '0;
            r_imr      <= '0;
            r_pid      <= '0;
            r_epc      <= '0;
            r_efg      <= '0;
            r_tlb      <= '0;
            r_ksp      <= '0;
            r_cdv      <= '0;
        end else begin
            if (we2 && (wa2 != 5'd0)) r_gpr[wa2] <= wd2;
            if (we1 && (wa1 != 5'd0)) r_gpr[wa1] <= wd1;
            if (!stall) begin
                r_rs1_data <= w_rs1_n;
                r_rs2_data <= w_rs2_n;
                r_cr_rdata <= w_cr_rd_n;
            end
            r_psr <= w_psr_n;
            r_isr <= w_isr_n;
            r_imr <= w_imr_n;
            r_pid <= w_pid_n;
            r_epc <= w_epc_n;
            r_efg <= w_efg_n;
            r_tlb <= w_tlb_n;
            r_ksp <= w_ksp_n;
            r_cdv <= w_cdv_n;
        end
    end

    assign rs1_data        = r_rs1_data;
    assign rs2_data        = r_rs2_data;
    assign cr_rdata        = r_cr_rdata;
    assign ret_val         = r_gpr[1];
    assign kmode           = r_psr[0];
    assign cdv             = r_cdv;
    assign interrupt_state = {16'd0, w_istate};

endmodule

// File: tb/tb_pipe_regfiles.sv
// Scoreboard bench for pipe_regfiles: stimulus queues hand-computed results due
// after the next edge; a monitor pops and compares them just after that edge.
module tb_pipe_regfiles;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [4:0]  rs1_addr, rs2_addr, wa1, wa2, cr_raddr;
    logic [31:0] rs1_data, rs2_data, wd1, wd2, ret_val, cr_rdata;
    logic        we1, we2, cr_we;
    logic        exc_in_wb, tlb_exc_in_wb, interrupt_in_wb, rfe_in_wb, rfi_in_wb;
    logic [31:0] epc, efg, tlb_addr, cdv, interrupt_state;
    logic [15:0] interrupts;
    logic        kmode;

    pipe_regfiles dut (
        .clk(clk), .rst(rst), .stall(stall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
        .ret_val(ret_val), .cr_raddr(cr_raddr), .cr_rdata(cr_rdata), .cr_we(cr_we),
        .exc_in_wb(exc_in_wb), .tlb_exc_in_wb(tlb_exc_in_wb),
        .interrupt_in_wb(interrupt_in_wb), .rfe_in_wb(rfe_in_wb), .rfi_in_wb(rfi_in_wb),
        .epc(epc), .efg(efg), .tlb_addr(tlb_addr), .interrupts(interrupts),
        .kmode(kmode), .cdv(cdv), .interrupt_state(interrupt_state)
    );

    always #5 clk = ~clk;

    localparam int K_RS1 = 0, K_RS2 = 1, K_CR = 2, K_RET = 3, K_KM = 4, K_IST = 5, K_CDV = 6;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RS1:   return rs1_data;
            K_RS2:   return rs2_data;
            K_CR:    return cr_rdata;
            K_RET:   return ret_val;
            K_KM:    return {31'd0, kmode};
            K_IST:   return interrupt_state;
            default: return cdv;
        endcase
    endfunction

    task automatic expect_next(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.due  = cyc + 1;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e   = sbq.pop_front();
                act = actual(e.kind);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        stall = 0; we1 = 0; we2 = 0; cr_we = 0;
        exc_in_wb = 0; tlb_exc_in_wb = 0; interrupt_in_wb = 0; rfe_in_wb = 0; rfi_in_wb = 0;
        wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0;
        epc = 0; efg = 0; tlb_addr = 0; interrupts = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst = 1; rs1_addr = 0; rs2_addr = 0; cr_raddr = 0;
        expect_next(K_RS1, 32'h0, "rst_rs1");
        expect_next(K_RS2, 32'h0, "rst_rs2");
        expect_next(K_CR,  32'h0, "rst_cr");
        expect_next(K_KM,  32'h1, "rst_kmode");
        expect_next(K_IST, 32'h0, "rst_istate");
        expect_next(K_RET, 32'h0, "rst_ret");
        expect_next(K_CDV, 32'h0, "rst_cdv");
        tick(); tick();
        rst = 0;

        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a); cr_raddr = 5'(a);
            expect_next(K_RS1, 32'h0, "init_rs1");
            expect_next(K_RS2, 32'h0, "init_rs2");
            expect_next(K_CR, (a == 0) ? 32'h1 : 32'h0, "init_cr");
            tick();
        end

        // GPR writes and forwarding
        we1 = 1; wa1 = 5; wd1 = 32'hDEADBEEF; rs1_addr = 5;
        expect_next(K_RS1, 32'hDEADBEEF, "fwd_r5");
        tick(); clr();
        we1 = 1; wa1 = 0; wd1 = 32'hFFFF; rs1_addr = 0;
        expect_next(K_RS1, 32'h0, "r0_zero");
        tick(); clr();
        we1 = 1; wa1 = 7; wd1 = 32'h11; we2 = 1; wa2 = 7; wd2 = 32'h22; rs2_addr = 7;
        expect_next(K_RS2, 32'h11, "dual_fwd_r7");
        tick(); clr();
        rs1_addr = 7;
        expect_next(K_RS1, 32'h11, "dual_store_r7");
        tick();
        we1 = 1; wa1 = 1; wd1 = 32'h42; rs2_addr = 1;
        expect_next(K_RS2, 32'h42, "fwd_r1");
        expect_next(K_RET, 32'h42, "ret_val");
        tick(); clr();
        we2 = 1; wa2 = 9; wd2 = 32'h99; rs1_addr = 9;
        expect_next(K_RS1, 32'h99, "port2_r9");
        tick(); clr();

        // Stall holds read data; writes still land
        rs1_addr = 5;
        expect_next(K_RS1, 32'hDEADBEEF, "pre_stall");
        tick();
        stall = 1; rs1_addr = 7; we1 = 1; wa1 = 5; wd1 = 32'h55;
        expect_next(K_RS1, 32'hDEADBEEF, "stall_hold1");
        tick(); clr();
        stall = 1;
        expect_next(K_RS1, 32'hDEADBEEF, "stall_hold2");
        tick(); clr();
        rs1_addr = 5;
        expect_next(K_RS1, 32'h55, "stall_release");
        tick();

        // Interrupt path
        cr_we = 1; wa1 = 3; wd1 = 32'h3; cr_raddr = 3;
        expect_next(K_CR, 32'h3, "imr_write");
        tick(); clr();
        cr_we = 1; wa1 = 0; wd1 = 32'h5; cr_raddr = 0;
        expect_next(K_CR, 32'h5, "psr_write");
        expect_next(K_KM, 32'h1, "psr_kmode");
        expect_next(K_IST, 32'h0, "istate_none");
        tick(); clr();
        interrupts = 16'h0002; cr_raddr = 2;
        expect_next(K_CR, 32'h2, "isr_capture");
        expect_next(K_IST, 32'h2, "istate_pend");
        tick(); clr();
        interrupt_in_wb = 1; epc = 32'h100; efg = 32'h7; cr_raddr = 4;
        expect_next(K_CR, 32'h100, "int_epc");
        expect_next(K_IST, 32'h0, "int_istate");
        expect_next(K_KM, 32'h1, "int_kmode");
        tick(); clr();
        cr_raddr = 2;
        expect_next(K_CR, 32'h0, "int_isr_clr");
        tick();
        cr_raddr = 0;
        expect_next(K_CR, 32'h3, "int_psr");
        tick();
        cr_raddr = 5;
        expect_next(K_CR, 32'h7, "int_efg");
        tick();

        // TLB exception and return
        cr_we = 1; wa1 = 0; wd1 = 32'h4; cr_raddr = 0;
        expect_next(K_CR, 32'h4, "psr_user");
        expect_next(K_KM, 32'h0, "user_kmode");
        tick(); clr();
        tlb_exc_in_wb = 1; tlb_addr = 32'hABC000; epc = 32'h200; cr_raddr = 6;
        expect_next(K_CR, 32'hABC000, "tlb_addr");
        expect_next(K_KM, 32'h1, "tlb_kmode");
        tick(); clr();
        cr_raddr = 4;
        expect_next(K_CR, 32'h200, "tlb_epc");
        tick();
        cr_raddr = 0;
        expect_next(K_CR, 32'h5, "tlb_psr");
        tick();
        rfe_in_wb = 1; cr_raddr = 0;
        expect_next(K_CR, 32'h4, "rfe_psr");
        expect_next(K_KM, 32'h0, "rfe_kmode");
        tick(); clr();

        // CDV, unmapped CR, event priority over cr_we
        cr_we = 1; wa1 = 8; wd1 = 32'h1234; cr_raddr = 8;
        expect_next(K_CR, 32'h1234, "cdv_read");
        expect_next(K_CDV, 32'h1234, "cdv_out");
        tick(); clr();
        cr_we = 1; wa1 = 12; wd1 = 32'hFFFF; cr_raddr = 12;
        expect_next(K_CR, 32'h0, "cr12_zero");
        tick(); clr();
        cr_we = 1; wa1 = 4; wd1 = 32'hAAAA; exc_in_wb = 1; epc = 32'h300; cr_raddr = 4;
        expect_next(K_CR, 32'h300, "exc_over_crwe");
        expect_next(K_KM, 32'h1, "exc_kmode");
        tick(); clr();
        rfi_in_wb = 1; cr_raddr = 0;
        expect_next(K_CR, 32'h4, "rfi_psr");
        expect_next(K_KM, 32'h0, "rfi_kmode");
        tick(); clr();
        cr_we = 1; wa1 = 2; wd1 = 32'hFFFF0001; interrupts = 16'h0100; cr_raddr = 2;
        expect_next(K_CR, 32'h101, "isr_write_or");
        expect_next(K_IST, 32'h1, "isr_masked");
        tick(); clr();

        repeat (3) tick();
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
